// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single request/ack memory port.
// Data has priority; a bounded streak of data grants keeps instruction fetch from starving.
module mem_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 2
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_RDATA,
    output logic        I_VALID,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [3:0]  D_BE,
    output logic [31:0] D_RDATA,
    output logic        D_VALID,
    output logic        ERR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BE,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        BUSY,
    output logic [3:0]  DBG_STATE
);

    // Handshake: I_REQ/D_REQ are levels held until the matching one-cycle VALID;
    // MEM_REQ is held with a constant command until MEM_ACK or timeout.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GNT_I = 4'b0010,
        GNT_D = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] SMAX  = 2'(STARVE_MAX);

    state_t      state_q;
    logic [7:0]  tcnt_q;
    logic [1:0]  streak_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        i_valid_q;
    logic        d_valid_q;
    logic        err_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic        at_limit_d;
    logic        grant_i_d;
    logic        grant_d_d;
    logic [1:0]  streak_d;

    always_comb begin
        at_limit_d = (streak_q == SMAX);
        grant_i_d  = I_REQ && (!D_REQ || at_limit_d);
        grant_d_d  = D_REQ && !grant_i_d;
        // A data grant only extends the streak while a fetch is actually waiting.
        streak_d   = I_REQ ? (at_limit_d ? SMAX : streak_q + 2'd1) : 2'd0;
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q     <= IDLE;
            tcnt_q      <= 8'd0;
            streak_q    <= 2'd0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_i_d) begin
                        state_q     <= GNT_I;
                        tcnt_q      <= 8'd0;
                        streak_q    <= 2'd0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= I_ADDR;
                        mem_wdata_q <= 32'd0;
                        mem_be_q    <= 4'b1111;
                    end else if (grant_d_d) begin
                        state_q     <= GNT_D;
                        tcnt_q      <= 8'd0;
                        streak_q    <= streak_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= D_WE;
                        mem_addr_q  <= D_ADDR;
                        mem_wdata_q <= D_WDATA;
                        mem_be_q    <= D_BE;
                    end
                end
                GNT_I, GNT_D: begin
                    // ACK takes precedence over a timeout in the same cycle.
                    if (MEM_ACK) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (state_q == GNT_I) begin
                            i_rdata_q <= MEM_RDATA;
                            i_valid_q <= 1'b1;
                        end else begin
                            d_rdata_q <= mem_we_q ? 32'd0 : MEM_RDATA;
                            d_valid_q <= 1'b1;
                        end
                    end else if (tcnt_q == TLAST) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (state_q == GNT_I) begin
                            i_rdata_q <= 32'd0;
                            i_valid_q <= 1'b1;
                        end else begin
                            d_rdata_q <= 32'd0;
                            d_valid_q <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign I_RDATA   = i_rdata_q;
    assign I_VALID   = i_valid_q;
    assign D_RDATA   = d_rdata_q;
    assign D_VALID   = d_valid_q;
    assign ERR       = err_q;
    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_BE    = mem_be_q;
    assign BUSY      = (state_q != IDLE);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random request/latency mixes,
// all compared against a transaction-level model of arbitration and completion.
module tb_mem_arbiter;

    localparam int TIMEOUT    = 16;
    localparam int STARVE_MAX = 2;

    logic        CLK = 1'b0;
    logic        RES_N;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [31:0] I_RDATA;
    logic        I_VALID;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [3:0]  D_BE;
    logic [31:0] D_RDATA;
    logic        D_VALID;
    logic        ERR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;
    logic        BUSY;
    logic [3:0]  DBG_STATE;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RES_N(RES_N),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_VALID(I_VALID),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
        .D_RDATA(D_RDATA), .D_VALID(D_VALID), .ERR(ERR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_BE(MEM_BE), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .BUSY(BUSY), .DBG_STATE(DBG_STATE)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          streak;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_q[$];
    logic        obs_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, MEM_REQ, 0);
        check({tag, "_mem_we"}, MEM_WE, 0);
        check({tag, "_mem_addr"}, MEM_ADDR, 0);
        check({tag, "_mem_wdata"}, MEM_WDATA, 0);
        check({tag, "_mem_be"}, MEM_BE, 0);
        check({tag, "_i_rdata"}, I_RDATA, 0);
        check({tag, "_d_rdata"}, D_RDATA, 0);
        check({tag, "_valids"}, {I_VALID, D_VALID}, 0);
        check({tag, "_err"}, ERR, 0);
        check({tag, "_busy"}, BUSY, 0);
    endtask

    // Entered at the falling edge of an IDLE cycle with requests already driven;
    // returns at the falling edge of the IDLE cycle following the response.
    // lat < TIMEOUT: ACK in that 0-based MEM_REQ cycle; otherwise no ACK at all.
    task automatic do_txn(input int lat, input logic [31:0] rdata);
        logic        win_i;
        logic        ewe;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        logic        eerr;
        logic [31:0] er;
        logic        done;

        win_i = I_REQ && (!D_REQ || streak == STARVE_MAX);
        if (win_i) begin
            streak = 0;
            ea = I_ADDR; ewe = 1'b0; ebe = 4'hF; ewd = 32'd0;
        end else begin
            streak = I_REQ ? ((streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1) : 0;
            ea = D_ADDR; ewe = D_WE; ebe = D_BE; ewd = D_WDATA;
        end

        @(negedge CLK);
        obs_i = (MEM_ADDR === I_ADDR) && I_REQ && (MEM_BE === 4'hF) && !MEM_WE;
        check("onehot_gnt", 32'($onehot(DBG_STATE)), 1);
        check("mem_we", MEM_WE, ewe);
        check("mem_be", MEM_BE, ebe);
        if (!win_i && ewe) check("mem_wdata", MEM_WDATA, ewd);

        done = 1'b0;
        for (int k = 0; k < TIMEOUT && !done; k++) begin
            check("mem_req_hi", MEM_REQ, 1);
            check("mem_addr", MEM_ADDR, ea);
            check("busy_gnt", BUSY, 1);
            if (k == lat) begin
                MEM_ACK = 1'b1;
                MEM_RDATA = rdata;
            end else begin
                MEM_RDATA = $urandom;
            end
            done = (k == lat) || (k == TIMEOUT - 1);
            @(negedge CLK);
            MEM_ACK = 1'b0;
        end

        eerr = (lat >= TIMEOUT);
        er = (eerr || ewe) ? 32'd0 : rdata;
        if (win_i) exp_i_rdata = er;
        else exp_d_rdata = er;

        check("resp_i_valid", I_VALID, win_i);
        check("resp_d_valid", D_VALID, !win_i);
        check("resp_err", ERR, eerr);
        check("resp_i_rdata", I_RDATA, exp_i_rdata);
        check("resp_d_rdata", D_RDATA, exp_d_rdata);
        check("resp_mem_req", MEM_REQ, 0);
        check("resp_busy", BUSY, 1);
        if (win_i) I_REQ = 1'b0;
        else D_REQ = 1'b0;
        MEM_ACK = 1'($urandom_range(0, 1));
        MEM_RDATA = $urandom;

        @(negedge CLK);
        MEM_ACK = 1'b0;
        check("idle_valids", {I_VALID, D_VALID}, 0);
        check("idle_err", ERR, 0);
        check("idle_busy", BUSY, 0);
        check("idle_i_rdata", I_RDATA, exp_i_rdata);
        check("idle_d_rdata", D_RDATA, exp_d_rdata);
    endtask

    task automatic set_d(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_WDATA = wd; D_BE = be;
    endtask

    initial begin
        int lat;
        RES_N = 1'b0;
        I_REQ = 1'b0; I_ADDR = 32'd0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 32'd0; D_WDATA = 32'd0; D_BE = 4'd0;
        MEM_RDATA = 32'd0; MEM_ACK = 1'b0;
        streak = 0; exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;

        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RES_N = 1'b1;
        @(negedge CLK);

        // Instruction fetch alone, ACK two cycles into the request
        I_REQ = 1'b1; I_ADDR = 32'h100;
        do_txn(2, 32'hDEADBEEF);
        check("fetch_rdata", I_RDATA, 32'hDEADBEEF);

        // Data write returns zero read data
        set_d(1'b1, 32'h40, 32'h12345678, 4'b0011);
        do_txn(0, 32'hAAAA5555);
        check("write_rdata", D_RDATA, 32'd0);

        // Timeout with no ACK, then ACK landing on the final cycle
        set_d(1'b0, 32'h44, 32'd0, 4'hF);
        do_txn(1000, 32'd0);
        set_d(1'b0, 32'h48, 32'd0, 4'hF);
        do_txn(TIMEOUT - 1, 32'hCAFEF00D);
        check("late_ack_rdata", D_RDATA, 32'hCAFEF00D);

        // Stray ACK while idle must not start anything
        MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFFFFFF;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        @(negedge CLK);
        check("stray_busy", BUSY, 0);
        check("stray_valids", {I_VALID, D_VALID}, 0);
        check("stray_d_rdata", D_RDATA, exp_d_rdata);

        // Starvation limit: expected grant order D D I D D I (1 = I)
        exp_q = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
        for (int n = 0; n < 6; n++) begin
            if (!I_REQ) begin I_REQ = 1'b1; I_ADDR = 32'h2000; end
            if (!D_REQ) set_d(1'b0, 32'h3000 + 32'(n), 32'd0, 4'hF);
            do_txn(1, 32'h5000 + 32'(n));
            check("grant_order", obs_i, exp_q.pop_front());
        end
        if (I_REQ || D_REQ) do_txn(0, 32'h600D);
        if (I_REQ || D_REQ) do_txn(0, 32'h600E);

        // Reset in the middle of a data grant, then a late ACK after release
        set_d(1'b0, 32'h80, 32'd0, 4'hF);
        @(negedge CLK);
        check("rst_pre_req", MEM_REQ, 1);
        @(negedge CLK);
        #2 RES_N = 1'b0;
        #1 check_all_zero("async_rst");
        D_REQ = 1'b0;
        @(negedge CLK);
        RES_N = 1'b1;
        MEM_ACK = 1'b1; MEM_RDATA = 32'h77777777;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        check_all_zero("post_rst");
        streak = 0; exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
        I_REQ = 1'b1; I_ADDR = 32'h104;
        do_txn(0, 32'h0BADF00D);

        // Random mix of requests, command fields and memory latencies
        for (int n = 0; n < 150; n++) begin
            if (!I_REQ && $urandom_range(0, 1) == 1) begin
                I_REQ = 1'b1; I_ADDR = $urandom;
            end
            if (!D_REQ && $urandom_range(0, 1) == 1)
                set_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            if (!I_REQ && !D_REQ) begin
                I_REQ = 1'b1; I_ADDR = $urandom;
            end
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
            else lat = $urandom_range(0, 4);
            do_txn(lat, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: MEM_REQ cycles without MEM_ACK before the access aborts (legal 2..255).
REQ-002 Parameter STARVE_MAX, default 2, meaning: consecutive data grants allowed while I_REQ is pending (legal 1..3).
REQ-003 CLK  in  1  single clock, all state updates on rising edge.
REQ-004 RES_N  in  1  reset, asynchronous, active-low.
REQ-005 I_REQ  in  1  instruction fetch request, level, held until I_VALID.
REQ-006 I_ADDR  in  32  fetch address, stable while I_REQ is high.
REQ-007 I_RDATA  out  32  fetched word, valid with I_VALID.
REQ-008 I_VALID  out  1  one-cycle fetch completion pulse.
REQ-009 D_REQ  in  1  data access request, level, held until D_VALID.
REQ-010 D_WE  in  1  1 = write, 0 = read.
REQ-011 D_ADDR / D_WDATA  in  32 / 32  data address and write data.
REQ-012 D_BE  in  4  write byte enables.
REQ-013 D_RDATA  out  32  read data, valid with D_VALID.
REQ-014 D_VALID  out  1  one-cycle data completion pulse.
REQ-015 ERR  out  1  high with I_VALID or D_VALID when the access timed out.
REQ-016 MEM_REQ  out  1  memory request, held until MEM_ACK or timeout.
REQ-017 MEM_WE / MEM_ADDR / MEM_WDATA / MEM_BE  out  1 / 32 / 32 / 4  registered memory command.
REQ-018 MEM_RDATA  in  32  memory read data, valid with MEM_ACK.
REQ-019 MEM_ACK  in  1  one-cycle memory completion.
REQ-020 BUSY  out  1  high in every state except IDLE.

Function
REQ-021 FSM states IDLE, GNT_I, GNT_D, RESP; state is one-hot encoded.
REQ-022 IDLE: at the edge where a request is sampled, the block SHALL latch the winner's command into the MEM_* registers and enter GNT_I or GNT_D, so MEM_REQ rises in the cycle after the request is first seen.
REQ-023 Arbitration SHALL give data priority, except that the block SHALL grant I when both request and the streak counter equals STARVE_MAX.
REQ-024 Streak counter: +1 on each D grant made while I_REQ is high; cleared on any I grant and on any D grant made with I_REQ low; it SHALL saturate at STARVE_MAX.
REQ-025 An instruction grant SHALL drive MEM_WE=0 and MEM_BE=4'b1111; a data grant SHALL copy D_WE, D_ADDR, D_WDATA and D_BE.
REQ-026 GNT_x: MEM_REQ=1 and MEM_* SHALL stay constant; the timeout counter increments each cycle without MEM_ACK.
REQ-027 On MEM_ACK in GNT_x, the block SHALL register MEM_RDATA, or 0 for writes, into x_RDATA, drop MEM_REQ, and enter RESP.
REQ-028 Timeout: when the counter reaches TIMEOUT-1 and MEM_ACK is low, the block SHALL drop MEM_REQ, set x_RDATA=0 and ERR=1, and enter RESP.
REQ-029 If MEM_ACK arrives in the same cycle as the timeout, ACK SHALL win and ERR=0.
REQ-030 RESP: exactly one of I_VALID/D_VALID SHALL be high for one cycle, ERR per REQ-027/028; REQ inputs are ignored and the next state is IDLE.
REQ-031 The requester SHALL deassert REQ in its VALID cycle; a REQ still high in the following IDLE cycle is a new request.
REQ-032 MEM_ACK outside GNT_x SHALL be ignored.
REQ-033 Latency with zero-wait memory (ACK in the first MEM_REQ cycle): REQ sampled at edge N, MEM_REQ in cycle N+1, VALID in cycle N+2, next grant possible at edge N+3.
REQ-034 x_RDATA SHALL hold its value until the next completion for that port.

Reset
REQ-035 RES_N low SHALL immediately force state IDLE, both counters 0, all MEM_* outputs 0, I_RDATA=D_RDATA=0, and I_VALID, D_VALID, ERR, BUSY all 0.
REQ-036 Reset during GNT_x SHALL abort the access with no VALID and no ERR; a MEM_ACK arriving after release SHALL be ignored per REQ-032.

Verification
REQ-037 I_REQ alone, I_ADDR=0x100, ACK after 2 cycles with RDATA=0xDEADBEEF -> MEM_ADDR=0x100, MEM_WE=0, MEM_BE=F, then I_VALID with I_RDATA=0xDEADBEEF, ERR=0.
REQ-038 I_REQ and D_REQ both held, D_REQ re-raised after each D_VALID, STARVE_MAX=2 -> grant order D, D, I, D, D, I.
REQ-039 D write, D_ADDR=0x40, D_WDATA=0x12345678, D_BE=0011 -> MEM_WE=1 with those values, D_VALID with D_RDATA=0.
REQ-040 No MEM_ACK, TIMEOUT=16 -> MEM_REQ high for 16 cycles, then D_VALID with ERR=1 and D_RDATA=0; ACK on cycle 16 -> ERR=0.
REQ-041 RES_N pulled low in GNT_D, then ACK after release -> all outputs 0, no VALID, BUSY=0, and the next I_REQ is served normally.
